matrix_stream_loader: RTL
=========================

# matrix_stream_loader

Parametrised loader that accepts one word stream and writes it, in order, into `NUM_BANKS` matrix memories. It is the generalised successor of the two-matrix fill controller and sits between the input stream and the A/B/... matrix RAMs of the multiplier. It adds a valid/ready handshake, a runtime element count, start/done control, and per-bank full flags so a bank is not overwritten before the compute engine releases it.

## Interface
- `NUM_BANKS`, 2: number of matrix memories, at least 1.
- `MEM_DEPTH`, 64: words per bank, at least 2.
- `DATA_WIDTH`, 32: stream and memory word width.
- `ADDR_WIDTH`, `$clog2(MEM_DEPTH)`: memory address width.
- `LEN_WIDTH`, `$clog2(MEM_DEPTH+1)`: element-count width.

Ports (name, direction, width, meaning):
- `data_clk`, in, 1: single clock for the stream and all memory write ports.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a load of all banks.
- `cfg_len`, in, `LEN_WIDTH`: words per bank, sampled on an accepted `start`.
- `data_valid`, in, 1: stream word valid.
- `data_ready`, out, 1: loader can accept a word.
- `data`, in, `DATA_WIDTH`: stream word.
- `wr_en`, out, `NUM_BANKS`: one-hot write enable, bit i for bank i.
- `wr_addr`, out, `ADDR_WIDTH`: write address, shared by all banks.
- `wr_data`, out, `DATA_WIDTH`: write data, shared by all banks.
- `bank_full`, out, `NUM_BANKS`: bank i holds a complete matrix.
- `bank_release`, in, `NUM_BANKS`: pulse from the consumer that clears `bank_full[i]`.
- `busy`, out, 1: a load is in progress.
- `load_done`, out, 1: one-cycle pulse when the last bank is written.

## Operation
- **State machine**, state type `load_state_t`:
  - IDLE: go to WAIT_BANK on `start`. Latch the effective length and set bank = 0, addr = 0.
  - WAIT_BANK: go to FILL when `bank_full[bank]` is 0.
  - FILL: on each accepted beat (`data_valid && data_ready`), write the word at addr and increment addr. On the last beat (addr == len-1), set `bank_full[bank]` and reset addr to 0.
    - If bank < NUM_BANKS-1: increment bank and go to WAIT_BANK.
    - Otherwise go to DONE.
  - DONE: pulse `load_done`, then go to IDLE.
- `data_ready` = (state == FILL), decoded from registered state. No combinational path from `data_valid` to `data_ready`.
- Effective length:
  - `cfg_len` of 0 or greater than `MEM_DEPTH` is clamped to `MEM_DEPTH`.
  - The latched value is stable for the whole load.
  - With length `MEM_DEPTH`, addr wraps from `MEM_DEPTH-1` to 0 at the bank boundary.
- `start` while `busy` is ignored; `cfg_len` is not re-sampled.
- **`bank_full` rules:**
  - Set on the last beat of a bank; cleared by `bank_release[i]`.
  - Set and release on the same bank in the same cycle: set wins.
  - Release of a bank that is not full: no effect.
  - The flags persist across loads. A new load stalls in WAIT_BANK until bank 0 is released.
- `wr_data` is 0 and `wr_en` is 0 whenever no beat was accepted in the previous cycle. `wr_addr` holds its last value.
- **Reset at any time:**
  - State → IDLE; all counters → 0; `bank_full` → 0.
  - Any in-flight beat is discarded with no write issued.
  - Outputs are 0 in the cycle after `rst` is sampled high.

## Timing
- Reset values: `data_ready`, `wr_en`, `wr_addr`, `wr_data`, `bank_full`, `busy` and `load_done` are all 0.
- `start` sampled at cycle T:
  - `busy` = 1 from T+1.
  - `data_ready` = 1 from T+2 if bank 0 is free.
- Write latency is 1 cycle. A beat accepted at cycle T drives `wr_en`, `wr_addr` and `wr_data` at T+1.
- Last beat of a bank accepted at T:
  - `bank_full[bank]` = 1 at T+1.
  - `data_ready` = 0 at T+1, since WAIT_BANK takes at least one bubble cycle.
- Last beat of the last bank accepted at T:
  - `load_done` = 1 and the final `wr_en` both appear at T+1.
  - `busy` falls at T+2.
- Throughput inside a bank is one word per cycle.

## Structure
- Package `matrix_mem_pkg` holds:
  - `load_state_t` (IDLE, WAIT_BANK, FILL, DONE), a 2-bit enum.
  - The localparam helpers for `ADDR_WIDTH` and `LEN_WIDTH` and for the clamp function.
- Sub-module `bank_fill_counter`:
  - Address counter with load/clear and a `last` flag compared against the latched length.
  - Instantiated once and shared across banks.
- The top-level holds the FSM, the bank index, the `bank_full` register, and the registered write port.

## Test plan
- **Full load:** reset, `cfg_len` = 64, NUM_BANKS = 2, 128 back-to-back beats with data = index → bank0 addr 0..63 = 0..63 and bank1 addr 0..63 = 64..127. `load_done` pulses once, on the cycle of the 128th `wr_en`.
- **Short length:** `cfg_len` = 5 → 5 writes per bank at addr 0..4. `bank_full` = 2'b01 after beat 5 and 2'b11 after beat 10.
- **Clamp:** `cfg_len` = 0 → 64 writes per bank. `cfg_len` = 100 → 64 writes per bank.
- **Backpressure on a full bank:** second `start` with `bank_full` = 2'b11 → `data_ready` stays 0. `bank_release[0]` → `data_ready` = 1 two cycles later. Simultaneous set and release at a bank boundary leaves `bank_full` = 1.
- **Gapped stream:** random `data_valid` gaps plus a `start` pulse while `busy` → writes land only on accepted beats, with addresses contiguous. The extra `start` is ignored.
- **Mid-load reset:** assert `rst` at beat 30 of bank 0 → all outputs 0 next cycle, no `wr_en` for beat 30. A new `start` begins again at bank 0, addr 0.

Source files
------------

// File: rtl/matrix_mem_pkg.sv
// Shared types and width/length helpers for the matrix stream loader.
package matrix_mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BANK = 2'd1,
        FILL      = 2'd2,
        DONE      = 2'd3
    } load_state_t;

    function automatic int addr_width_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int len_width_f(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A zero or oversized request means "fill the whole bank".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        return ((len == 0) || (len > depth)) ? depth : len;
    endfunction

endpackage

// File: rtl/bank_fill_counter.sv
// Write-address counter shared by all banks; holds the latched length and
// flags the final address of a bank.
module bank_fill_counter #(
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LEN_WIDTH-1:0]  load_len,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;

    assign last = (LEN_WIDTH'(addr_q) == (len_q - 1'b1));
    assign addr = addr_q;

    always_comb begin
        addr_d = addr_q;
        len_d  = len_q;
        if (load) begin
            addr_d = '0;
            len_d  = load_len;
        end else if (inc) begin
            addr_d = last ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
        end else begin
            addr_q <= addr_d;
            len_q  <= len_d;
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// Streams words into NUM_BANKS matrix memories in order, one bank after another,
// waiting on each bank until the consumer has released it.
module matrix_stream_loader
    import matrix_mem_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int MEM_DEPTH  = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = addr_width_f(MEM_DEPTH),
    parameter int LEN_WIDTH  = len_width_f(MEM_DEPTH)
) (
    input  logic                  data_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [NUM_BANKS-1:0]  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [NUM_BANKS-1:0]  bank_full,
    input  logic [NUM_BANKS-1:0]  bank_release,
    output logic                  busy,
    output logic                  load_done
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    load_state_t            state_q, state_d;
    logic [BANK_W-1:0]      bank_q, bank_d;
    logic [NUM_BANKS-1:0]   bank_full_q, bank_full_d;
    logic [NUM_BANKS-1:0]   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

    logic [NUM_BANKS-1:0]   bank_sel;
    logic [LEN_WIDTH-1:0]   eff_len;
    logic                   cnt_load, cnt_inc, cnt_last;
    logic [ADDR_WIDTH-1:0]  cnt_addr;

    assign eff_len = LEN_WIDTH'(clamp_len(32'(cfg_len), 32'(MEM_DEPTH)));

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_sel
        assign bank_sel[gi] = (bank_q == BANK_W'(gi));
    end

    bank_fill_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_counter (
        .clk      (data_clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_len (eff_len),
        .inc      (cnt_inc),
        .addr     (cnt_addr),
        .last     (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        bank_full_d = bank_full_q & ~bank_release;
        wr_en_d     = '0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = '0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = WAIT_BANK;
                    bank_d   = '0;
                    cnt_load = 1'b1;
                end
            end
            WAIT_BANK: begin
                if (!bank_full_q[bank_q]) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (data_valid) begin
                    cnt_inc   = 1'b1;
                    wr_en_d   = bank_sel;
                    wr_addr_d = cnt_addr;
                    wr_data_d = data;
                    if (cnt_last) begin
                        // Applied after the release mask so a same-cycle set wins.
                        bank_full_d[bank_q] = 1'b1;
                        if (bank_q == BANK_W'(NUM_BANKS - 1)) begin
                            state_d = DONE;
                        end else begin
                            bank_d  = bank_q + 1'b1;
                            state_d = WAIT_BANK;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge data_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bank_q      <= '0;
            bank_full_q <= '0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            bank_full_q <= bank_full_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign data_ready = (state_q == FILL);
    assign busy       = (state_q != IDLE);
    assign load_done  = (state_q == DONE);
    assign bank_full  = bank_full_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule
